// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Module : synth_pkg
// Shared sizes, index/phase types and phase-accumulator FSM states.
// Rev    : 1.0
// ============================================================================
package synth_pkg;

    localparam int NUM_VOICES  = 8;
    localparam int PHASE_WIDTH = 32;
    localparam int VOICE_W     = $clog2(NUM_VOICES);

    typedef logic [VOICE_W-1:0]     voice_idx_t;
    typedef logic [PHASE_WIDTH-1:0] phase_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } pa_state_t;

    // Indices wider than the voice array are legal on the port and must be dropped.
    function automatic logic voice_in_range(input voice_idx_t v);
        return int'(v) < NUM_VOICES;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_accumulator_bank_if.sv
`default_nettype none
// ============================================================================
// Module : phase_accumulator_bank_if
// Note on/off command channel (valid/ready) into the phase accumulator bank.
// Rev    : 1.0
// ============================================================================
interface phase_accumulator_bank_if;
    import synth_pkg::*;

    logic       cmd_valid_in;
    logic       cmd_ready_out;
    voice_idx_t cmd_voice_in;
    logic       cmd_on_in;
    phase_t     cmd_incr_in;

    modport master (
        output cmd_valid_in,
        output cmd_voice_in,
        output cmd_on_in,
        output cmd_incr_in,
        input  cmd_ready_out
    );

    modport slave (
        input  cmd_valid_in,
        input  cmd_voice_in,
        input  cmd_on_in,
        input  cmd_incr_in,
        output cmd_ready_out
    );

endinterface
`default_nettype wire

// File: rtl/phase_accumulator_bank.sv
`default_nettype none
// ============================================================================
// Module : phase_accumulator_bank
// Per-voice phase accumulators swept once per sample tick through one shared adder.
// Rev    : 1.0
// ============================================================================
module phase_accumulator_bank
    import synth_pkg::*;
(
    input  wire logic                  clk_in,
    input  wire logic                  rst_in,
    input  wire logic                  sample_tick_in,
    phase_accumulator_bank_if.slave    cmd,
    output phase_t                     phase_out [NUM_VOICES-1:0],
    output logic [NUM_VOICES-1:0]      gate_out,
    output logic                       phase_valid_out,
    output logic                       busy_out,
    output logic                       overrun_out,
    input  wire logic                  overrun_clr_in
);

    localparam voice_idx_t LAST_VOICE = voice_idx_t'(NUM_VOICES - 1);

    pa_state_t             state_q,   state_d;
    voice_idx_t            voice_q,   voice_d;
    phase_t                phase_q   [NUM_VOICES-1:0];
    phase_t                phase_d   [NUM_VOICES-1:0];
    phase_t                incr_q    [NUM_VOICES-1:0];
    phase_t                incr_d    [NUM_VOICES-1:0];
    logic [NUM_VOICES-1:0] gate_q,    gate_d;
    logic                  overrun_q, overrun_d;

    logic   cmd_ready;
    logic   cmd_fire;
    phase_t sweep_sum;

    // A tick in IDLE wins over a waiting command, which keeps the command
    // write and the sweep write in disjoint cycles.
    assign cmd_ready         = (state_q == IDLE) && !sample_tick_in;
    assign cmd_fire          = cmd.cmd_valid_in && cmd_ready;
    assign cmd.cmd_ready_out = cmd_ready;

    assign sweep_sum = phase_q[voice_q] + incr_q[voice_q];

    always_comb begin
        state_d   = state_q;
        voice_d   = voice_q;
        phase_d   = phase_q;
        incr_d    = incr_q;
        gate_d    = gate_q;
        overrun_d = overrun_q;

        if (sample_tick_in && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_in) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (sample_tick_in) begin
                    state_d = SWEEP;
                    voice_d = '0;
                end else if (cmd_fire && voice_in_range(cmd.cmd_voice_in)) begin
                    if (cmd.cmd_on_in) begin
                        gate_d[cmd.cmd_voice_in]  = 1'b1;
                        incr_d[cmd.cmd_voice_in]  = cmd.cmd_incr_in;
                        phase_d[cmd.cmd_voice_in] = '0;
                    end else begin
                        gate_d[cmd.cmd_voice_in]  = 1'b0;
                    end
                end
            end
            SWEEP: begin
                if (gate_q[voice_q]) begin
                    phase_d[voice_q] = sweep_sum;
                end
                if (voice_q == LAST_VOICE) begin
                    state_d = DONE;
                end
                voice_d = voice_q + voice_idx_t'(1);
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            voice_q   <= '0;
            gate_q    <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
                incr_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            voice_q   <= voice_d;
            gate_q    <= gate_d;
            overrun_q <= overrun_d;
            phase_q   <= phase_d;
            incr_q    <= incr_d;
        end
    end

    assign phase_out       = phase_q;
    assign gate_out        = gate_q;
    assign phase_valid_out = (state_q == DONE);
    assign busy_out        = (state_q != IDLE);
    assign overrun_out     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_accumulator_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_phase_accumulator_bank
// Scoreboarded bench: directed scenarios then random commands/ticks vs a voice model.
// Rev    : 1.0
// ============================================================================
module tb_phase_accumulator_bank;
    import synth_pkg::*;

    localparam int NV = NUM_VOICES;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              sample_tick_in;
    logic              overrun_clr_in;
    phase_t            phase_out [NV-1:0];
    logic [NV-1:0]     gate_out;
    logic              phase_valid_out;
    logic              busy_out;
    logic              overrun_out;

    phase_accumulator_bank_if ifc ();

    phase_accumulator_bank dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_tick_in  (sample_tick_in),
        .cmd             (ifc),
        .phase_out       (phase_out),
        .gate_out        (gate_out),
        .phase_valid_out (phase_valid_out),
        .busy_out        (busy_out),
        .overrun_out     (overrun_out),
        .overrun_clr_in  (overrun_clr_in)
    );

    always #5 clk_in = ~clk_in;

    int unsigned cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct packed {
        int unsigned          cyc;
        logic [NV-1:0]        gate;
        logic [NV-1:0][31:0]  ph;
    } exp_t;

    exp_t expq [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: voice state plus the window of cycles the bank is busy.
    logic [31:0]   m_phase [NV];
    logic [31:0]   m_incr  [NV];
    logic [NV-1:0] m_gate;
    bit            m_ovr;
    int            bs = 1;
    int            be = 0;
    bit            checks_on = 0;

    bit            pend_valid = 0;
    logic [2:0]    pend_voice = '0;
    bit            pend_on    = 0;
    logic [31:0]   pend_incr  = '0;
    int            acc_cyc    = -1;
    int            last_c     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_phases(input string tag);
        for (int i = 0; i < NV; i++)
            chk($sformatf("%s_phase[%0d]", tag, i), 64'(phase_out[i]), 64'(m_phase[i]));
    endtask

    task automatic set_cmd(input logic [2:0] v, input bit on, input logic [31:0] incr);
        pend_valid = 1;
        pend_voice = v;
        pend_on    = on;
        pend_incr  = incr;
    endtask

    task automatic step(input bit tick, input bit clr, input bit rst_n);
        int   c;
        bit   mbusy;
        exp_t e;
        exp_t keep [$];
        @(posedge clk_in);
        #1;
        sample_tick_in   = tick;
        overrun_clr_in   = clr;
        rst_in           = rst_n;
        ifc.cmd_valid_in = pend_valid;
        ifc.cmd_voice_in = pend_voice;
        ifc.cmd_on_in    = pend_on;
        ifc.cmd_incr_in  = pend_incr;
        c      = int'(cyc);
        last_c = c;
        #2;
        mbusy = (c >= bs) && (c <= be);
        if (checks_on) begin
            chk("cmd_ready", 64'(ifc.cmd_ready_out), 64'(!mbusy && !tick));
            chk("busy", 64'(busy_out), 64'(mbusy));
            chk("overrun", 64'(overrun_out), 64'(m_ovr));
            chk("gate", 64'(gate_out), 64'(m_gate));
        end
        if (!rst_n) begin
            for (int i = 0; i < NV; i++) begin
                m_phase[i] = '0;
                m_incr[i]  = '0;
            end
            m_gate = '0;
            m_ovr  = 0;
            bs     = 1;
            be     = 0;
            // A pulse already showing this cycle survives; later ones are aborted.
            foreach (expq[k]) if (int'(expq[k].cyc) <= c) keep.push_back(expq[k]);
            expq = keep;
        end else begin
            if (tick && mbusy) m_ovr = 1;
            else if (clr)      m_ovr = 0;
            if (tick && !mbusy) begin
                e.cyc  = c + NV + 1;
                e.gate = m_gate;
                for (int i = 0; i < NV; i++) begin
                    if (m_gate[i]) m_phase[i] = m_phase[i] + m_incr[i];
                    e.ph[i] = m_phase[i];
                end
                expq.push_back(e);
                bs = c + 1;
                be = c + NV + 1;
            end else if (pend_valid && !mbusy && !tick) begin
                if (pend_on) begin
                    m_gate[pend_voice]  = 1'b1;
                    m_incr[pend_voice]  = pend_incr;
                    m_phase[pend_voice] = '0;
                end else begin
                    m_gate[pend_voice]  = 1'b0;
                end
                pend_valid = 0;
                acc_cyc    = c;
            end
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding tick.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                e = expq.pop_front();
                chk("missing_valid", 64'(cyc), 64'(e.cyc));
            end
            if (phase_valid_out === 1'b1) begin
                if (expq.size() == 0) begin
                    chk("unexpected_valid", 64'(phase_valid_out), 64'(0));
                end else begin
                    e = expq.pop_front();
                    chk("valid_latency", 64'(cyc), 64'(e.cyc));
                    chk("valid_gate", 64'(gate_out), 64'(e.gate));
                    for (int i = 0; i < NV; i++)
                        chk($sformatf("valid_phase[%0d]", i), 64'(phase_out[i]), 64'(e.ph[i]));
                end
            end
        end
    end

    initial begin
        int          t_tick;
        logic [31:0] frozen;
        rst_in           = 1'b0;
        sample_tick_in   = 1'b0;
        overrun_clr_in   = 1'b0;
        ifc.cmd_valid_in = 1'b0;
        ifc.cmd_voice_in = '0;
        ifc.cmd_on_in    = 1'b0;
        ifc.cmd_incr_in  = '0;
        for (int i = 0; i < NV; i++) begin
            m_phase[i] = '0;
            m_incr[i]  = '0;
        end
        m_gate = '0;
        m_ovr  = 0;

        repeat (3) step(0, 0, 0);
        checks_on = 1;
        step(0, 0, 1);
        check_phases("reset");

        // Four ticks on a single voice.
        set_cmd(3'd2, 1, 32'h0100_0000);
        step(0, 0, 1);
        step(0, 0, 1);
        repeat (4) begin
            step(1, 0, 1);
            repeat (19) step(0, 0, 1);
        end
        check_phases("four_ticks");
        chk("v2_after_4", 64'(phase_out[2]), 64'(32'h0400_0000));

        // Modular wrap.
        set_cmd(3'd0, 1, 32'hC000_0000);
        step(0, 0, 1);
        step(1, 0, 1);
        repeat (12) step(0, 0, 1);
        chk("wrap1", 64'(phase_out[0]), 64'(32'hC000_0000));
        step(1, 0, 1);
        repeat (12) step(0, 0, 1);
        chk("wrap2", 64'(phase_out[0]), 64'(32'h8000_0000));

        // Overrun, clear, and set-beats-clear.
        step(1, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 0, 1);
        step(0, 0, 1);
        chk("overrun_set", 64'(overrun_out), 64'(1));
        repeat (8) step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 1);
        chk("overrun_clr", 64'(overrun_out), 64'(0));
        step(1, 0, 1);
        step(0, 0, 1);
        step(1, 1, 1);
        step(0, 0, 1);
        chk("overrun_set_wins", 64'(overrun_out), 64'(1));
        repeat (8) step(0, 1, 1);

        // Command colliding with a tick waits until the cycle after DONE.
        set_cmd(3'd5, 1, 32'h0123_4567);
        step(1, 0, 1);
        t_tick = last_c;
        for (int n = 0; n < 30 && pend_valid; n++) step(0, 0, 1);
        chk("cmd_after_done", 64'(acc_cyc), 64'(t_tick + NV + 2));
        step(0, 0, 1);
        chk("gate5_on", 64'(gate_out[5]), 64'(1));

        // Note off freezes a voice.
        set_cmd(3'd2, 0, 32'hFFFF_FFFF);
        step(0, 0, 1);
        frozen = m_phase[2];
        repeat (3) begin
            step(1, 0, 1);
            repeat (12) step(0, 0, 1);
        end
        chk("v2_frozen", 64'(phase_out[2]), 64'(frozen));
        check_phases("note_off");

        // Reset in the middle of a sweep.
        step(1, 0, 1);
        repeat (3) step(0, 0, 1);
        repeat (2) step(0, 0, 0);
        repeat (NV + 3) step(0, 0, 1);
        check_phases("mid_sweep_reset");

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if (!pend_valid && $urandom_range(0, 99) < 35)
                set_cmd(3'($urandom_range(0, NV - 1)), ($urandom_range(0, 3) != 0), $urandom);
            step($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3, 1);
        end
        pend_valid = 0;
        repeat (NV + 4) step(0, 0, 1);
        check_phases("final");
        chk("queue_drained", 64'(expq.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
